// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the downstream sequence-detector bench.
// Holds the state encoding and the default word width and idle line level.
package seq_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } serState_e;

    localparam int   DEF_WIDTH      = 8;
    localparam logic DEF_IDLE_LEVEL = 1'b0;

endpackage : seq_pkg

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector: words arrive over valid/ready and leave
// one bit per clock on a_out, with a one-word pend buffer so back-to-back words stay gapless.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH      = DEF_WIDTH,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             a_out,
    output logic             a_valid,
    output logic             word_last,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    serState_e        state_q,      state_d;
    logic [WIDTH-1:0] shift_q,      shift_d;
    logic [CNT_W-1:0] bitCnt_q,     bitCnt_d;
    logic [WIDTH-1:0] pend_q,       pend_d;
    logic             pendValid_q,  pendValid_d;
    logic             aOut_q,       aOut_d;
    logic             aValid_q,     aValid_d;
    logic             wordLast_q,   wordLast_d;

    logic             accept;
    logic             free;
    logic             loadEn;
    logic [WIDTH-1:0] loadWord;

    // The bit that goes out first (or next, after a shift) always sits at the head end.
    function automatic logic headBit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign din_ready = !rst && !pendValid_q;
    assign busy      = (state_q == SER_SHIFT) || pendValid_q;
    assign a_out     = aOut_q;
    assign a_valid   = aValid_q;
    assign word_last = wordLast_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bitCnt_d    = bitCnt_q;
        pend_d      = pend_q;
        pendValid_d = pendValid_q;
        aOut_d      = aOut_q;
        aValid_d    = aValid_q;
        wordLast_d  = wordLast_q;
        loadEn      = 1'b0;
        loadWord    = '0;

        accept = din_valid && din_ready;
        free   = (state_q == SER_IDLE) || (bitCnt_q == LAST_CNT);

        // When the shifter frees up, the pend word has priority over a fresh din.
        if (free) begin
            if (pendValid_q) begin
                loadEn      = 1'b1;
                loadWord    = pend_q;
                pendValid_d = accept;
                if (accept) begin
                    pend_d = din;
                end
            end else if (accept) begin
                loadEn   = 1'b1;
                loadWord = din;
            end else begin
                state_d    = SER_IDLE;
                bitCnt_d   = '0;
                aValid_d   = 1'b0;
                aOut_d     = IDLE_LEVEL;
                wordLast_d = 1'b0;
            end
        end else begin
            shift_d    = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
            bitCnt_d   = bitCnt_q + CNT_W'(1);
            aOut_d     = headBit(shift_d);
            wordLast_d = (bitCnt_d == LAST_CNT);
            if (accept) begin
                pend_d      = din;
                pendValid_d = 1'b1;
            end
        end

        if (loadEn) begin
            state_d    = SER_SHIFT;
            shift_d    = loadWord;
            bitCnt_d   = '0;
            aOut_d     = headBit(loadWord);
            aValid_d   = 1'b1;
            wordLast_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SER_IDLE;
            shift_q     <= '0;
            bitCnt_q    <= '0;
            pend_q      <= '0;
            pendValid_q <= 1'b0;
            aOut_q      <= IDLE_LEVEL;
            aValid_q    <= 1'b0;
            wordLast_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitCnt_q    <= bitCnt_d;
            pend_q      <= pend_d;
            pendValid_q <= pendValid_d;
            aOut_q      <= aOut_d;
            aValid_q    <= aValid_d;
            wordLast_q  <= wordLast_d;
        end
    end

endmodule : seq_bit_serializer

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: an MSB-first and an LSB-first instance share one stimulus stream
// and are compared every cycle against a word-queue model, plus literal bit patterns.
module tb_seq_bit_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;

    logic mReady, mAOut, mAValid, mLast, mBusy;
    logic lReady, lAOut, lAValid, lLast, lBusy;

    int errors = 0;
    int checks = 0;
    bit checkEn = 0;

    // Word-level reference: the word on the line, its bit position, and words waiting behind it.
    bit         mActive = 0;
    logic [7:0] mWord   = '0;
    int         mPos    = 0;
    logic [7:0] mQ[$];

    bit   recEn = 0;
    logic recValid[$];
    logic recLast[$];
    logic recReady[$];

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dutM (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(mReady),
        .a_out(mAOut), .a_valid(mAValid), .word_last(mLast), .busy(mBusy)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dutL (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(lReady),
        .a_out(lAOut), .a_valid(lAValid), .word_last(lLast), .busy(lBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        @(negedge clk);
        din_valid = v;
        din       = d;
    endtask

    function automatic logic expBit(input bit msb);
        if (!mActive) return 1'b0;
        return msb ? mWord[7 - mPos] : mWord[mPos];
    endfunction

    // Model: accepted words join the queue; whenever the line is free the oldest word starts.
    always @(posedge clk) begin
        if (rst) begin
            mQ.delete();
            mActive = 0;
            mPos    = 0;
        end else begin
            if (din_valid && mQ.size() == 0) mQ.push_back(din);
            if (!mActive || mPos == 7) begin
                if (mQ.size() > 0) begin
                    mWord   = mQ.pop_front();
                    mPos    = 0;
                    mActive = 1;
                end else begin
                    mActive = 0;
                end
            end else begin
                mPos++;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #1;
        if (checkEn) begin
            checkOutput("M.a_valid",   mAValid, mActive);
            checkOutput("M.a_out",     mAOut,   expBit(1));
            checkOutput("M.word_last", mLast,   mActive && mPos == 7);
            checkOutput("M.busy",      mBusy,   mActive || mQ.size() > 0);
            checkOutput("M.din_ready", mReady,  !rst && mQ.size() == 0);
            checkOutput("L.a_valid",   lAValid, mActive);
            checkOutput("L.a_out",     lAOut,   expBit(0));
            checkOutput("L.word_last", lLast,   mActive && mPos == 7);
            checkOutput("L.busy",      lBusy,   mActive || mQ.size() > 0);
            checkOutput("L.din_ready", lReady,  !rst && mQ.size() == 0);
        end
        if (recEn) begin
            recValid.push_back(mAValid);
            recLast.push_back(mLast);
            recReady.push_back(mReady);
        end
    end

    // Returns right after the posedge at which the word was accepted.
    task automatic offerWord(input logic [7:0] w);
        int guard;
        applyStimulus(1'b1, w);
        guard = 0;
        while (!mReady && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) checkOutput("acceptTimeout", 0, 1);
        @(posedge clk);
    endtask

    // seqM/seqL list the expected line bits with the first bit sent in position 7.
    task automatic runSingle(input string tag, input logic [7:0] w,
                             input logic [7:0] seqM, input logic [7:0] seqL);
        offerWord(w);
        #2;
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #2;
            end
            checkOutput({tag, ".M.bit"},  mAOut,   seqM[7 - i]);
            checkOutput({tag, ".L.bit"},  lAOut,   seqL[7 - i]);
            checkOutput({tag, ".model"},  expBit(1), seqM[7 - i]);
            checkOutput({tag, ".valid"},  mAValid, 1'b1);
            checkOutput({tag, ".last"},   mLast,   (i == 7));
        end
        @(posedge clk);
        #2;
        checkOutput({tag, ".after.valid"}, mAValid, 1'b0);
        checkOutput({tag, ".after.aout"},  mAOut,   1'b0);
        checkOutput({tag, ".after.Laout"}, lAOut,   1'b0);
    endtask

    initial begin
        int runStart, runLen, lastCnt, sawLow, lastOk, quiet;

        rst       = 1'b1;
        din_valid = 1'b0;
        din       = '0;

        // Reset held for three clocks, then released.
        @(posedge clk);
        checkEn = 1;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst.a_valid",   mAValid, 1'b0);
        checkOutput("rst.a_out",     mAOut,   1'b0);
        checkOutput("rst.din_ready", mReady,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rel.din_ready", mReady, 1'b1);
        checkOutput("rel.busy",      mBusy,  1'b0);

        // Single words in both bit orders.
        runSingle("B2", 8'hB2, 8'b1011_0010, 8'b0100_1101);
        runSingle("01", 8'h01, 8'b0000_0001, 8'b1000_0000);

        // Three words offered back to back must form one gapless 24-bit run.
        @(negedge clk);
        recEn = 1;
        offerWord(8'hF0);
        offerWord(8'h0F);
        offerWord(8'hAA);
        #2;
        din_valid = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        recEn = 0;
        runStart = -1;
        runLen   = 0;
        lastCnt  = 0;
        sawLow   = 0;
        lastOk   = 1;
        for (int i = 0; i < recValid.size(); i++) begin
            if (recValid[i] && runStart < 0) runStart = i;
            if (recLast[i]) lastCnt++;
            if (!recReady[i]) sawLow = 1;
        end
        if (runStart >= 0) begin
            for (int i = runStart; i < recValid.size() && recValid[i]; i++) begin
                runLen++;
                if (recLast[i] !== ((runLen % 8) == 0)) lastOk = 0;
            end
        end
        checkOutput("b2b.runLen",    runLen,  24);
        checkOutput("b2b.lastCount", lastCnt, 3);
        checkOutput("b2b.lastPos",   lastOk,  1);
        checkOutput("b2b.readyDrop", sawLow,  1);

        // Reset during bit 4 of 8'hFF with 8'h55 waiting in the pend buffer.
        offerWord(8'hFF);
        offerWord(8'h55);
        #2;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("mid.pendFull", mReady, 1'b0);
        checkOutput("mid.bit4",     mAValid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("mid.a_valid", mAValid, 1'b0);
        checkOutput("mid.a_out",   mAOut,   1'b0);
        checkOutput("mid.busy",    mBusy,   1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid.pendClear", mReady, 1'b1);
        quiet = 0;
        repeat (12) begin
            @(posedge clk);
            #2;
            if (mAValid) quiet++;
        end
        checkOutput("mid.55neverSent", quiet, 0);

        // Random traffic with occasional resets; the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 299) == 0);
            din_valid = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 60 : 95));
            din       = 8'($urandom);
        end
        @(negedge clk);
        rst       = 1'b0;
        din_valid = 1'b0;
        repeat (25) @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_bit_serializer
